// File: rtl/param_ctrl_unit.sv
// Handshake-driven sequencer for the accumulator/bus datapath: latches one instruction
// per start, steps it through T0..Tk and pulses done (with illegal on a bad instruction).

// Per-register slot: bus select and load strobe for register IDX.
module pcu_reg_slot #(
  parameter int RIW = 2,
  parameter int IDX = 0
) (
  input  logic           src_rs,
  input  logic           src_rd,
  input  logic           ld_rd,
  input  logic [RIW-1:0] rd,
  input  logic [RIW-1:0] rs,
  output logic           sel,
  output logic           ld
);
  logic hit_rd, hit_rs;
  assign hit_rd = (32'(rd) == IDX);
  assign hit_rs = (32'(rs) == IDX);
  assign sel    = (src_rs && hit_rs) || (src_rd && hit_rd);
  assign ld     = ld_rd && hit_rd;
endmodule

module param_ctrl_unit #(
  parameter int NREG = 4,
  parameter int SC_W = 2,
  parameter int RIW  = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3+2*RIW:0]     instr,
  output logic                 busy,
  output logic                 done,
  output logic                 illegal,
  output logic [2**SC_W-1:0]   T,
  output logic [NREG+1:0]      sel_A,
  output logic [NREG-1:0]      ld,
  output logic                 LD_AC,
  output logic                 LD_outr,
  output logic [1:0]           alu_op
);
  localparam int TW = 2**SC_W;
  localparam int IW = 4 + 2*RIW;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  typedef enum logic [2:0] {SRC_NONE, SRC_RS, SRC_RD, SRC_AC, SRC_EXT} src_t;

  state_t         state, state_nx;
  logic [SC_W-1:0] sc, sc_nx, last;
  logic [IW-1:0]  ir, ir_nx;

  logic [3:0]     opcode;
  logic [RIW-1:0] rd, rs;
  logic           bad, act;
  src_t           src;
  logic           ld_rd;
  logic           ld_ac;
  logic           ld_out;
  logic [1:0]     alu;

  assign opcode = ir[IW-1 -: 4];
  assign rd     = ir[2*RIW-1 -: RIW];
  assign rs     = ir[RIW-1:0];

  // Index check only bites when NREG is not a power of two.
  assign bad  = (opcode > 4'd8) || (32'(rd) >= NREG) || (32'(rs) >= NREG);
  assign last = bad ? '0 : ((opcode == 4'd8) ? SC_W'(3) : SC_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nx;
      sc    <= sc_nx;
      ir    <= ir_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sc_nx    = sc;
    ir_nx    = ir;
    case (state)
      IDLE: if (start) begin
        state_nx = EXEC;
        ir_nx    = instr;
        sc_nx    = '0;
      end
      EXEC: begin
        if (sc == last) state_nx = DONE;
        else            sc_nx    = sc + SC_W'(1);
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Step decode; T0 is decode-only, so nothing is driven while sc is zero.
  always_comb begin
    src    = SRC_NONE;
    ld_rd  = 1'b0;
    ld_ac  = 1'b0;
    ld_out = 1'b0;
    alu    = 2'b00;
    act    = (state == EXEC) && !bad && (sc != '0);
    if (act) begin
      case (opcode)
        4'd1: if (sc == SC_W'(1)) begin src = SRC_RS;  ld_rd  = 1'b1; end
        4'd2: if (sc == SC_W'(1)) begin src = SRC_RS;  ld_ac  = 1'b1; end
        4'd3: if (sc == SC_W'(1)) begin src = SRC_AC;  ld_rd  = 1'b1; end
        4'd4: if (sc == SC_W'(1)) begin src = SRC_RS;  ld_ac  = 1'b1; alu = 2'b01; end
        4'd5: if (sc == SC_W'(1)) begin src = SRC_RS;  ld_ac  = 1'b1; alu = 2'b10; end
        4'd6: if (sc == SC_W'(1)) begin src = SRC_EXT; ld_rd  = 1'b1; end
        4'd7: if (sc == SC_W'(1)) begin src = SRC_AC;  ld_out = 1'b1; end
        4'd8: begin
          if (sc == SC_W'(1)) begin src = SRC_RS; ld_ac = 1'b1; end
          if (sc == SC_W'(2)) begin src = SRC_RD; ld_ac = 1'b1; alu = 2'b01; end
          if (sc == SC_W'(3)) begin src = SRC_AC; ld_rd = 1'b1; end
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    pcu_reg_slot #(.RIW(RIW), .IDX(i)) u_slot (
      .src_rs (src == SRC_RS),
      .src_rd (src == SRC_RD),
      .ld_rd  (ld_rd),
      .rd     (rd),
      .rs     (rs),
      .sel    (sel_A[i]),
      .ld     (ld[i])
    );
  end

  assign sel_A[NREG]   = (src == SRC_AC);
  assign sel_A[NREG+1] = (src == SRC_EXT);
  assign LD_AC   = ld_ac;
  assign LD_outr = ld_out;
  assign alu_op  = alu;
  assign busy    = (state == EXEC);
  assign done    = (state == DONE);
  assign illegal = (state == DONE) && bad;
  assign T       = (state == EXEC) ? (TW'(1) << sc) : '0;
endmodule

// File: doc/param_ctrl_unit.md
# param_ctrl_unit

Parametrised, handshake-driven control unit for the accumulator/bus datapath. It latches one instruction per start request and sequences it through timing steps T0..Tk with a sequence counter. In each step it drives one-hot bus source selects, register load strobes, AC/output-register loads and an ALU op, then pulses `done`. It sits between the instruction source and the register/AC/bus datapath, and generalises the fixed R1–R3 control unit to NREG registers, multi-step instructions and illegal-instruction reporting.

## Interface
- `NREG`, 4: number of general registers R0..R(NREG-1); legal range 2..16.
- `SC_W`, 2: sequence-counter width; T bus width is 2**SC_W; must be >= 2.
- `RIW`, $clog2(NREG): register index field width (derived).
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: request to execute `instr`; sampled only in IDLE.
- `instr` in 4+2*RIW: {opcode[3:0], rd[RIW-1:0], rs[RIW-1:0]}.
- `busy` out 1: high from the cycle after an accepted start until the final execution step, inclusive.
- `done` out 1: one-cycle pulse after the final step.
- `illegal` out 1: valid with `done`; high for a bad opcode or out-of-range index.
- `T` out 2**SC_W: one-hot timing step; all zero in IDLE and DONE.
- `sel_A` out NREG+2: one-hot bus source. Bit i selects Ri, bit NREG selects AC, bit NREG+1 selects external input. All zero when the bus is undriven.
- `ld` out NREG: per-register load strobes.
- `LD_AC` out 1: accumulator load.
- `LD_outr` out 1: output register load.
- `alu_op` out 2: 00 = pass bus to AC, 01 = AC+bus, 10 = AC−bus; 00 when LD_AC is low.

## Operation
- States: IDLE, EXEC, DONE.
  - IDLE -> EXEC when `start`=1; IR <= instr, SC <= 0.
  - EXEC increments SC each cycle; EXEC -> DONE after the last step of the opcode.
  - DONE -> IDLE unconditionally.
- T0 is the decode step for every opcode. No strobes and no sel_A are driven in T0. Legality is checked in T0.
- Opcodes and actions (all strobes are combinational from state/SC/IR, high for exactly one cycle):
  - 0 NOP: T1 has no strobes.
  - 1 MOV: T1 sel_A=Rrs, ld[rd].
  - 2 LDA: T1 sel_A=Rrs, LD_AC, alu 00.
  - 3 STA: T1 sel_A=AC, ld[rd].
  - 4 ADD: T1 sel_A=Rrs, LD_AC, alu 01.
  - 5 SUB: T1 sel_A=Rrs, LD_AC, alu 10.
  - 6 IN: T1 sel_A=ext, ld[rd].
  - 7 OUT: T1 sel_A=AC, LD_outr.
  - 8 ADDR (Rrd <= Rrd+Rrs, AC clobbered):
    - T1 sel_A=Rrs, LD_AC, alu 00.
    - T2 sel_A=Rrd, LD_AC, alu 01.
    - T3 sel_A=AC, ld[rd].
  - 9..15 illegal.
- Illegal instruction (bad opcode, or rd/rs >= NREG when NREG is not a power of two):
  - EXEC lasts T0 only, with no strobes; DONE has `illegal`=1.
- `start` in EXEC or DONE is ignored; the instruction is not queued.
- `illegal` is held low except in the DONE cycle.
- At most one bit of sel_A is set. At most one of ld/LD_AC/LD_outr is set, except none in T0.

## Timing
- Reset (rst=0, asynchronous):
  - state IDLE, SC=0, IR=0.
  - All outputs 0 immediately, without waiting for a clock edge.
- Reset asserted mid-instruction aborts it. No `done` is produced, and no strobe is driven after reset assertion.
- Start accepted at edge e0 (start high in IDLE):
  - cycle 1: T0.
  - cycles 2..k+1: T1..Tk.
  - cycle k+2: DONE.
  - cycle k+3: IDLE.
  - k=1 for single-step ops, k=3 for ADDR, k=0 for illegal.
- Start-to-done latency is 2 cycles for illegal, 3 for single-step ops, 5 for ADDR. The next start is accepted no earlier than the first IDLE cycle.
- `busy` is high in all EXEC cycles and low in DONE and IDLE.
- SC never wraps: SC_W>=2 guarantees T3 exists.

## Test plan
- MOV R2,R1 (NREG=4): start at cycle 0 -> cycle 1 T=0001; cycle 2 T=0010, sel_A=000010, ld=0100; cycle 3 done=1, illegal=0; cycle 4 IDLE.
- ADDR R3,R0 -> three steps:
  - T1 sel_A=000001, LD_AC, alu 00.
  - T2 sel_A=001000, LD_AC, alu 01.
  - T3 sel_A=010000, ld=1000.
  - done at cycle 5.
- OUT then IN back-to-back, with start held high continuously:
  - OUT: T1 sel_A=010000, LD_outr.
  - start during EXEC/DONE is ignored; IN starts only at the first IDLE cycle.
  - IN: T1 sel_A=100000, ld[rd].
- Illegal opcode 12 -> T0 cycle with no strobes, then done=1 and illegal=1 two cycles after start. No ld, LD_AC or LD_outr ever high.
- NREG=3, MOV with rs=3 -> illegal=1 at done, no strobes. MOV with rs=2 is legal with sel_A=00100.
- ADDR with rst pulled low asynchronously mid-T2 -> all outputs 0 within the same cycle. No done follows. After release, a new start executes normally.
